soc_system_sysid_checker: RTL
=============================

Name: soc_system_sysid_checker

Overview:
- Avalon-MM read master that fetches the system ID word and the build-timestamp word from the sysid slave.
- Compares both words against expected parameter values and reports pass/fail to HPS-visible status logic.
- Sits between the boot/reset sequencer and the sysid control slave.
- Supports waitrequest stalls and variable read latency (readdatavalid), with a per-read timeout and bounded retry.

Parameters:
- EXPECTED_ID, 32'h12345678, value required at address 0
- EXPECTED_TS, 32'h5AD6CE4E, value required at address 1
- TIMEOUT_CYCLES, 255, cycles allowed from read issue to readdatavalid; 8-bit counter, range 1..255
- MAX_RETRIES, 3, extra attempts of a timed-out read before failing; range 0..7

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; launches a check sequence
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  high while a sequence runs
- done  out  1  one-cycle pulse when a sequence ends
- pass  out  1  sticky result of the last sequence
- fail_code  out  2  0 = none, 1 = ID mismatch, 2 = TS mismatch, 3 = timeout
- id_value  out  32  last ID word captured
- ts_value  out  32  last timestamp word captured

Behaviour:
- All logic is clocked on the rising edge of clock.
- Reset drives every output to 0 (avm_address, avm_read, busy, done, pass, fail_code, id_value, ts_value). FSM goes to IDLE; retry and timeout counters clear.
- FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE:
  - start=1 moves to REQ_ID next cycle.
  - busy rises in the same cycle the FSM leaves IDLE.
  - pass and fail_code clear at that point.
- REQ_x:
  - avm_read=1, with avm_address 0 (ID) or 1 (TS).
  - Address and read stay stable while avm_waitrequest=1.
  - The cycle with avm_read=1 and avm_waitrequest=0 is acceptance. avm_read drops the next cycle and the FSM moves to WAIT_x.
  - The timeout counter loads 0 at acceptance.
- WAIT_x:
  - The counter increments each cycle.
  - avm_readdatavalid=1 captures avm_readdata into id_value/ts_value.
  - Readdatavalid in the acceptance cycle itself is also legal. Capture it and skip WAIT_x.
- Data checks:
  - ID captured and == EXPECTED_ID → REQ_TS.
  - ID captured and != EXPECTED_ID → FINISH, fail_code=1.
  - TS captured and == EXPECTED_TS → FINISH with pass=1.
  - TS captured and != EXPECTED_TS → FINISH, fail_code=2.
- Timeout:
  - Triggers when the counter reaches TIMEOUT_CYCLES with no readdatavalid.
  - If retries used < MAX_RETRIES: increment retries and return to the same REQ_x.
  - Otherwise: FINISH, fail_code=3.
  - The retry count is per sequence, shared across both reads, and cleared on start.
- Late data: readdatavalid outside WAIT_x and outside an acceptance cycle is ignored, including late data from a timed-out read.
- Simultaneous events: if readdatavalid and timeout occur in the same cycle, the data wins.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Minimum latency, zero-wait slave with 1-cycle data: start to done = 6 cycles.
- start while busy=1 is ignored; no queuing.
- Reset mid-sequence: avm_read drops on the next edge. Any in-flight readdatavalid after reset is ignored.

Optional Feature:
- Macro: SYSID_CHECKER_AUTOSTART_EN.
- Defined: an internal pulse equivalent to start fires automatically 16 cycles after reset deasserts, once per reset. The external start input remains functional.
- Undefined: sequences begin only on start. No post-reset counter is synthesized.

Test Plan:
- Zero-wait slave, 1-cycle latency, returns 0x12345678 then 0x5AD6CE4E; pulse start → done after 6 cycles, pass=1, fail_code=0, id_value=0x12345678, ts_value=0x5AD6CE4E.
- Slave holds waitrequest 5 cycles on each read, latency 3 → avm_address/avm_read stable during stall, pass=1, no retries consumed.
- Address 0 returns 0xDEADBEEF → address 1 never issued, done with pass=0, fail_code=1, id_value=0xDEADBEEF.
- ID correct, TS read returns 0x00000000 → pass=0, fail_code=2, ts_value=0.
- Slave never asserts readdatavalid, TIMEOUT_CYCLES=4, MAX_RETRIES=2 → exactly 3 read acceptances at address 0, then fail_code=3. Then drive a stray readdatavalid while IDLE → no capture, no done.
- Assert reset while in WAIT_TS, deliver readdatavalid 2 cycles later → all outputs 0 and stay 0. A following start gives a normal pass. With SYSID_CHECKER_AUTOSTART_EN defined and no start pulse, the sequence begins 16 cycles after reset release.

Source files
------------

// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker: Avalon-MM read master that fetches the sysid ID word
// (address 0) and the build timestamp (address 1). It compares both against the
// expected values and reports pass/fail_code to status logic.
// Optional macro SYSID_CHECKER_AUTOSTART_EN: launches one sequence 16 cycles
// after reset is released, in addition to the external start input.
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h12345678,
    parameter logic [31:0] EXPECTED_TS    = 32'h5AD6CE4E,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int unsigned TW = 8;
    localparam int unsigned RW = 3;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_ID   = 2'd1;
    localparam logic [1:0] FC_TS   = 2'd2;
    localparam logic [1:0] FC_TMO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        FINISH
    } state_t;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] retry_cnt;
    logic          launch;
    logic          accept;
    logic          in_req;
    logic          in_wait;
    logic          take;
    logic          tmo_hit;
    logic          can_retry;

`ifdef SYSID_CHECKER_AUTOSTART_EN
    logic [4:0] auto_cnt;
    logic       auto_fired;

    // Post-reset delay counter; fires a single launch on the 16th cycle after release.
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_cnt   <= 5'd0;
            auto_fired <= 1'b0;
        end else if (!auto_fired) begin
            auto_cnt <= auto_cnt + 5'd1;
            if (auto_cnt == 5'd15) begin
                auto_fired <= 1'b1;
            end
        end
    end

    assign launch = start | (!auto_fired && (auto_cnt == 5'd15));
`else
    assign launch = start;
`endif

    // The acceptance cycle may already carry read data; it is captured right there.
    assign accept    = avm_read && !avm_waitrequest;
    assign in_req    = (state == REQ_ID) || (state == REQ_TS);
    assign in_wait   = (state == WAIT_ID) || (state == WAIT_TS);
    assign take      = avm_readdatavalid && ((in_req && accept) || in_wait);
    assign tmo_hit   = in_wait && !avm_readdatavalid && (tmo_cnt == TMO_LAST);
    assign can_retry = (retry_cnt < RETRY_MAX);

    // Sequence FSM with registered bus and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= REQ_ID;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        fail_code   <= FC_NONE;
                        retry_cnt   <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                    end
                end

                REQ_ID, WAIT_ID: begin
                    if (state == REQ_ID && accept) begin
                        avm_read <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= WAIT_ID;
                    end
                    if (take) begin
                        id_value <= avm_readdata;
                        if (avm_readdata == EXPECTED_ID) begin
                            state       <= REQ_TS;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b1;
                        end else begin
                            state     <= FINISH;
                            fail_code <= FC_ID;
                        end
                    end else if (state == WAIT_ID) begin
                        if (tmo_hit) begin
                            if (can_retry) begin
                                retry_cnt <= retry_cnt + RW'(1);
                                state     <= REQ_ID;
                                avm_read  <= 1'b1;
                            end else begin
                                state     <= FINISH;
                                fail_code <= FC_TMO;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end

                REQ_TS, WAIT_TS: begin
                    if (state == REQ_TS && accept) begin
                        avm_read <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= WAIT_TS;
                    end
                    if (take) begin
                        ts_value <= avm_readdata;
                        state    <= FINISH;
                        if (avm_readdata == EXPECTED_TS) begin
                            pass <= 1'b1;
                        end else begin
                            fail_code <= FC_TS;
                        end
                    end else if (state == WAIT_TS) begin
                        if (tmo_hit) begin
                            if (can_retry) begin
                                retry_cnt <= retry_cnt + RW'(1);
                                state     <= REQ_TS;
                                avm_read  <= 1'b1;
                            end else begin
                                state     <= FINISH;
                                fail_code <= FC_TMO;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end

                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
